// File: rtl/prime_prefetch_pkg.sv
// rtl/prime_prefetch_pkg.sv - shared types and default sizing for the prime prefetcher
// Purpose : FSM state enum and default WIDTH/DEPTH used by prime_prefetch,
//           its interface and the prime_fifo sub-module.
// Ports   : none (package).
package prime_prefetch_pkg;

  localparam int PF_WIDTH = 16;
  localparam int PF_DEPTH = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GO    = 3'd1,
    GUARD = 3'd2,
    WAIT  = 3'd3,
    HALT  = 3'd4
  } pf_state_t;

endpackage

// File: rtl/prime_prefetch_if.sv
// rtl/prime_prefetch_if.sv - primogen and consumer signal bundle for prime_prefetch
// Purpose : groups the primogen handshake and the consumer-side FIFO view.
// Signals : pg_go, pg_ready, pg_error, pg_res (primogen side);
//           pop, valid, prime, exhausted (consumer side).
// Modports: master = prime_prefetch, slave = primogen + consumer environment.
interface prime_prefetch_if
  import prime_prefetch_pkg::*;
#(
  parameter int WIDTH = PF_WIDTH
) ();

  logic             pg_go;
  logic             pg_ready;
  logic             pg_error;
  logic [WIDTH-1:0] pg_res;
  logic             pop;
  logic             valid;
  logic [WIDTH-1:0] prime;
  logic             exhausted;

  modport master (
    output pg_go, valid, prime, exhausted,
    input  pg_ready, pg_error, pg_res, pop
  );

  modport slave (
    input  pg_go, valid, prime, exhausted,
    output pg_ready, pg_error, pg_res, pop
  );

endinterface

// File: rtl/prime_fifo.sv
// rtl/prime_fifo.sv - show-ahead circular FIFO holding prefetched primes
// Purpose : DEPTH-entry (power of two) FIFO; dout shows the head, 0 when empty.
// Ports   : clk, rst (sync, active-high); push/din write; pop reads the head
//           (ignored when empty); dout, empty, full, count ($clog2(DEPTH)+1 bits).
module prime_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_pop;

  // Pop on an empty FIFO is dropped entirely so pointers and count stay put.
  assign w_do_pop = pop & ~empty;

  // Pointers are exactly AW bits, so the increment wraps modulo DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) begin
        r_mem[r_wr_ptr] <= din;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign empty = (r_count == '0);
  assign full  = (r_count == CW'(DEPTH));
  assign count = r_count;
  assign dout  = empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/prime_prefetch.sv
// rtl/prime_prefetch.sv - keeps a FIFO of primes topped up from a primogen engine
// Purpose : issues single-cycle go pulses to primogen whenever a FIFO slot is
//           free, pushes each result in order, and goes sticky-exhausted on error.
// Ports   : clk, rst (sync, active-high, shared with primogen);
//           bus (prime_prefetch_if.master): pg_go/pg_ready/pg_error/pg_res to
//           primogen, pop/valid/prime/exhausted to the consumer;
//           produced_cnt (16-bit saturating push count) only when
//           PRIME_PREFETCH_STATS_EN is defined.
module prime_prefetch
  import prime_prefetch_pkg::*;
#(
  parameter int WIDTH = PF_WIDTH,
  parameter int DEPTH = PF_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  prime_prefetch_if.master       bus
`ifdef PRIME_PREFETCH_STATS_EN
  ,
  output logic [15:0]            produced_cnt
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  pf_state_t       r_state;
  pf_state_t       w_next;
  logic            r_exhausted;
  logic            w_set_exh;
  logic            w_res_ok;
  logic            w_push;
  logic            w_empty;
  logic            w_full;
  logic [CW-1:0]   w_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_exhausted <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_set_exh) begin
        r_exhausted <= 1'b1;
      end
    end
  end

  // A go is only issued while the FIFO has room, so the slot for the result
  // is reserved up front; the FIFO can only shrink while the request is out.
  always_comb begin
    w_next    = r_state;
    w_set_exh = 1'b0;
    w_res_ok  = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.pg_ready) begin
          if (bus.pg_error) begin
            w_set_exh = 1'b1;
            w_next    = HALT;
          end else if (w_count < CW'(DEPTH)) begin
            w_next = GO;
          end
        end
      end
      GO:    w_next = GUARD;
      // pg_ready still shows the previous result here; primogen has not
      // yet registered go, so this cycle must not look at it.
      GUARD: w_next = WAIT;
      WAIT: begin
        if (bus.pg_ready) begin
          if (bus.pg_error) begin
            w_set_exh = 1'b1;
            w_next    = HALT;
          end else begin
            w_res_ok = 1'b1;
            w_next   = IDLE;
          end
        end
      end
      HALT:    w_next = HALT;
      default: w_next = IDLE;
    endcase
  end

  // w_full can never be set here given the issue rule; it only keeps a
  // broken issue path from overwriting the head entry.
  assign w_push = w_res_ok & ~w_full;

  prime_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (bus.pop),
    .din   (bus.pg_res),
    .dout  (bus.prime),
    .empty (w_empty),
    .full  (w_full),
    .count (w_count)
  );

  assign bus.pg_go     = (r_state == GO);
  assign bus.valid     = ~w_empty;
  assign bus.exhausted = r_exhausted;

`ifdef PRIME_PREFETCH_STATS_EN
  logic [15:0] r_produced_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_produced_cnt <= '0;
    end else if (w_push && (r_produced_cnt != 16'hFFFF)) begin
      r_produced_cnt <= r_produced_cnt + 16'd1;
    end
  end

  assign produced_cnt = r_produced_cnt;
`endif

endmodule

// File: doc/prime_prefetch.md
PRIME_PREFETCH -- requirements
Module: prime_prefetch

Interface
REQ-001 Parameter WIDTH, default 16: prime width; SHALL match the primogen result width.
REQ-002 Parameter DEPTH, default 4: prefetch FIFO entries; SHALL be a power of two, at least 2.
REQ-003 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 pg_go  out  1  single-cycle start pulse to primogen.
REQ-006 pg_ready  in  1  primogen idle / result valid.
REQ-007 pg_error  in  1  primogen overflow, qualified by pg_ready.
REQ-008 pg_res  in  WIDTH  primogen result.
REQ-009 pop  in  1  consumer takes the head entry this cycle.
REQ-010 valid  out  1  FIFO non-empty.
REQ-011 prime  out  WIDTH  FIFO head, show-ahead; meaningful only while valid.
REQ-012 exhausted  out  1  sticky; primogen reported error and no further primes will be produced.

Function
REQ-013 FSM states SHALL be IDLE, GO, GUARD, WAIT and HALT.
REQ-014 IDLE->GO SHALL occur when pg_ready=1, pg_error=0 and (count + 0) < DEPTH, so that a slot is reserved before issue.
REQ-015 In GO, pg_go SHALL be 1 for exactly that one cycle; the next state SHALL be GUARD.
REQ-016 GUARD SHALL last one cycle and SHALL ignore pg_ready, giving primogen one clock to register go; the next state SHALL be WAIT.
REQ-017 In WAIT with pg_ready=1 and pg_error=0, pg_res SHALL be pushed at that edge, valid SHALL be visible the next cycle, and the FSM SHALL return to IDLE.
REQ-018 In WAIT with pg_ready=1 and pg_error=1, nothing SHALL be pushed, exhausted SHALL be set and the FSM SHALL enter HALT.
REQ-019 In IDLE with pg_ready=1 and pg_error=1, the FSM SHALL set exhausted and enter HALT.
REQ-020 HALT SHALL be absorbing until rst; the FIFO SHALL still drain via pop.
REQ-021 pg_go SHALL never be asserted in two consecutive cycles, nor while not in GO.
REQ-022 The pg_res value present before the first go after reset SHALL never be pushed.
REQ-023 pop while valid=0 SHALL be ignored, with no pointer or count change.
REQ-024 Simultaneous push and pop SHALL leave count unchanged, with both pointers advancing.
REQ-025 A push at count=DEPTH SHALL be impossible by construction (REQ-014); the bench SHALL assert this.
REQ-026 Pointers SHALL wrap modulo DEPTH; count SHALL be $clog2(DEPTH)+1 bits wide.
REQ-027 FIFO output order SHALL equal primogen result order.

Reset
REQ-028 On rst: state=IDLE, pg_go=0, FIFO empty (valid=0), prime=0, exhausted=0, pointers=0.
REQ-029 rst asserted mid-operation, in any state, SHALL discard in-flight and buffered results.
REQ-030 Primogen is reset by the same rst; this block SHALL NOT drive primogen reset.

Configuration
REQ-031 Macro PRIME_PREFETCH_STATS_EN defined: add output produced_cnt, 16 bits, reset 0, incremented on each push and saturating at 16'hFFFF.
REQ-032 Macro undefined: port produced_cnt and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-033 The shared package SHALL hold the FSM state enum (pf_state_t) and the default WIDTH and DEPTH constants.
REQ-034 The FIFO SHALL be a sub-module prime_fifo (WIDTH, DEPTH; push, pop, din, dout, empty, full, count).
REQ-035 The FSM and issue logic SHALL stay in prime_prefetch.

Verification
Bench uses a primogen model: sequence 2,3,5,7,11,13,..., ready low for 3 cycles after go.
REQ-036 Reset release, no pop -> pushes of 2,3,5,7; then count=4, pg_go stays 0, valid=1, prime=2.
REQ-037 From full, pop each cycle for 4 cycles -> outputs 2,3,5,7; refill continues with 11,13,...; pg_go is never in back-to-back cycles.
REQ-038 Pop on the same cycle as a push at count=2 -> count stays 2, order preserved.
REQ-039 Model raises pg_error on the 3rd result -> only 2,3 are pushed; exhausted=1; FSM in HALT; after two pops valid=0 permanently.
REQ-040 rst pulsed in WAIT with 2 entries buffered -> next cycle valid=0, exhausted=0; restart yields 2 first.
REQ-041 PRIME_PREFETCH_STATS_EN defined, 5 results pushed -> produced_cnt=5; with the macro undefined, the build has no produced_cnt port.
